// File: rtl/gray_f32_to_u8_writer.sv
// Float gray pixel -> rounded/saturated byte, written to sequential frame-buffer addresses.
// Latency 2 cycles accept-to-write; in_ready only in RUN, no downstream backpressure.
module gray_f32_to_u8_writer #(
  parameter int ADDR_W = 10,
  parameter int NPIX   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   sat_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  localparam logic [ADDR_W:0] LP_LAST = (ADDR_W+1)'(NPIX - 1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W:0]   r_acc_cnt;
  logic              w_accept;
  logic              w_last;
  logic              w_start;

  logic              r_s1_vld;
  logic              r_s1_zero;
  logic              r_s1_sat;
  logic [8:0]        r_s1_t;

  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_next_addr;
  logic [7:0]        r_wr_data;
  logic [ADDR_W:0]   r_sat_cnt;

  logic              w_sign;
  logic [7:0]        w_exp;
  logic [22:0]       w_man;
  logic              w_nan;
  logic              w_zero;
  logic              w_big;
  logic [4:0]        w_shift;
  logic [8:0]        w_t;
  logic [8:0]        w_r9;
  logic              w_s2_sat;
  logic [7:0]        w_s2_data;

  assign w_accept = in_valid & in_ready;
  assign w_last   = w_accept && (r_acc_cnt == LP_LAST);
  assign w_start  = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // FLUSH ends once S1 is empty: the last write is then leaving S2 this cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_FLUSH;
      S_FLUSH: if (!r_s1_vld) w_next = S_DONE;
      S_DONE:  if (start) w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == S_RUN);
    busy     = (r_state == S_RUN) || (r_state == S_FLUSH);
    done     = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst)           r_acc_cnt <= '0;
    else if (w_start)  r_acc_cnt <= '0;
    else if (w_accept) r_acc_cnt <= r_acc_cnt + 1'b1;
  end

  // x = {1,m} * 2^(e-150); t = floor(x*2) for e in 126..134, so r = (t+1)>>1.
  assign w_sign  = in_data[31];
  assign w_exp   = in_data[30:23];
  assign w_man   = in_data[22:0];
  assign w_nan   = (w_exp == 8'd255) && (w_man != 23'd0);
  assign w_zero  = w_sign || w_nan || (w_exp < 8'd126);
  assign w_big   = !w_zero && (w_exp >= 8'd135);
  assign w_shift = 5'(8'd149 - w_exp);
  assign w_t     = 9'({1'b1, w_man} >> w_shift);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_zero <= 1'b0;
      r_s1_sat  <= 1'b0;
      r_s1_t    <= '0;
    end else begin
      r_s1_vld  <= w_accept;
      r_s1_zero <= w_zero;
      r_s1_sat  <= w_big;
      r_s1_t    <= w_t;
    end
  end

  assign w_r9      = 9'(({1'b0, r_s1_t} + 10'd1) >> 1);
  assign w_s2_sat  = !r_s1_zero && (r_s1_sat || w_r9[8]);
  assign w_s2_data = r_s1_zero ? 8'd0 : (w_s2_sat ? 8'd255 : w_r9[7:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_next_addr <= '0;
      r_wr_data   <= '0;
      r_sat_cnt   <= '0;
    end else begin
      r_wr_en <= r_s1_vld;
      if (w_start) begin
        r_wr_addr   <= '0;
        r_next_addr <= '0;
        r_sat_cnt   <= '0;
      end else if (r_s1_vld) begin
        r_wr_data   <= w_s2_data;
        r_wr_addr   <= r_next_addr;
        r_next_addr <= r_next_addr + 1'b1;
        if (w_s2_sat) r_sat_cnt <= r_sat_cnt + 1'b1;
      end
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign sat_cnt = r_sat_cnt;

endmodule

// File: tb/tb_gray_f32_to_u8_writer.sv
// Scoreboard bench for gray_f32_to_u8_writer with 4-pixel frames.
module tb_gray_f32_to_u8_writer;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [31:0]   in_data = 32'd0;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;
  logic          done;
  logic [AW:0]   sat_cnt;

  gray_f32_to_u8_writer #(.ADDR_W(AW), .NPIX(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [7:0]    d;
    logic [AW-1:0] a;
    int            c;
    logic          s;
  } exp_t;

  exp_t sbq[$];
  int   exp_addr = 0;
  int   exp_sat = 0;
  int   last_wr_cyc = 0;

  always @(negedge clk) begin : mon
    exp_t e;
    if (wr_en === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_wr", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        if (e.s) exp_sat++;
        chk("wr_data", 32'(wr_data), 32'(e.d));
        chk("wr_addr", 32'(wr_addr), 32'(e.a));
        chk("wr_latency", cyc, e.c);
        chk("sat_cnt", 32'(sat_cnt), exp_sat);
      end
      last_wr_cyc = cyc;
    end
  end

  // Stimulus table: four frames of four pixels (value, expected byte, saturated).
  logic [31:0] vals [16];
  logic [7:0]  exps [16];
  logic        sats [16];

  initial begin
    vals[0]  = 32'h437F0000; exps[0]  = 8'd255; sats[0]  = 1'b0;
    vals[1]  = 32'h43800000; exps[1]  = 8'd255; sats[1]  = 1'b1;
    vals[2]  = 32'h7F800000; exps[2]  = 8'd255; sats[2]  = 1'b1;
    vals[3]  = 32'h3F000000; exps[3]  = 8'd1;   sats[3]  = 1'b0;
    vals[4]  = 32'h3EFFFFFF; exps[4]  = 8'd0;   sats[4]  = 1'b0;
    vals[5]  = 32'h42FF0000; exps[5]  = 8'd128; sats[5]  = 1'b0;
    vals[6]  = 32'h42F6E979; exps[6]  = 8'd123; sats[6]  = 1'b0;
    vals[7]  = 32'h437F7FFF; exps[7]  = 8'd255; sats[7]  = 1'b0;
    vals[8]  = 32'hBF800000; exps[8]  = 8'd0;   sats[8]  = 1'b0;
    vals[9]  = 32'h80000000; exps[9]  = 8'd0;   sats[9]  = 1'b0;
    vals[10] = 32'h7FC00000; exps[10] = 8'd0;   sats[10] = 1'b0;
    vals[11] = 32'h00000001; exps[11] = 8'd0;   sats[11] = 1'b0;
    vals[12] = 32'h41200000; exps[12] = 8'd10;  sats[12] = 1'b0;
    vals[13] = 32'h3FC00000; exps[13] = 8'd2;   sats[13] = 1'b0;
    vals[14] = 32'h40200000; exps[14] = 8'd3;   sats[14] = 1'b0;
    vals[15] = 32'hFF800000; exps[15] = 8'd0;   sats[15] = 1'b0;
  end

  task automatic send(input logic [31:0] d, input logic [7:0] e, input logic s);
    exp_t it;
    bit   got;
    got = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        it.d = e;
        it.a = exp_addr[AW-1:0];
        it.c = cyc + 2;
        it.s = s;
        sbq.push_back(it);
        exp_addr++;
        got = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_idx(input int k);
    send(vals[k], exps[k], sats[k]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_addr = 0;
    exp_sat  = 0;
    @(negedge clk);
    chk("start_in_ready", 32'(in_ready), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    chk("start_wr_addr", 32'(wr_addr), 32'd0);
    chk("start_sat_cnt", 32'(sat_cnt), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input logic [31:0] want_sat);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("done_latency", cyc, last_wr_cyc + 1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_in_ready", 32'(in_ready), 32'd0);
    chk("pending_writes", sbq.size(), 32'd0);
    chk("frame_sat_cnt", 32'(sat_cnt), want_sat);
    @(posedge clk); #1;
  endtask

  task automatic chk_quiet();
    chk("q_wr_en", 32'(wr_en), 32'd0);
    chk("q_wr_addr", 32'(wr_addr), 32'd0);
    chk("q_wr_data", 32'(wr_data), 32'd0);
    chk("q_busy", 32'(busy), 32'd0);
    chk("q_done", 32'(done), 32'd0);
    chk("q_sat_cnt", 32'(sat_cnt), 32'd0);
    chk("q_in_ready", 32'(in_ready), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk_quiet();
    @(posedge clk); #1;

    // Frame A: saturation, back-to-back accepts
    do_start();
    for (int k = 0; k < 4; k++) send_idx(k);
    wait_done(32'd2);

    // Frame B: start from DONE, gapped valid, start ignored mid-RUN
    do_start();
    send_idx(4);
    start = 1'b1;
    idle(1);
    start = 1'b0;
    send_idx(5);
    send_idx(6);
    idle(1);
    send_idx(7);
    @(negedge clk);
    chk("rdy_after_last", 32'(in_ready), 32'd0);
    chk("busy_in_flush", 32'(busy), 32'd1);
    @(posedge clk); #1;
    wait_done(32'd0);

    // Frame C: negative, NaN, denormal
    do_start();
    for (int k = 8; k < 12; k++) send_idx(k);
    wait_done(32'd0);

    // Reset one cycle after an accept discards the in-flight pixel
    do_start();
    send(32'h7F800000, 8'd255, 1'b1);
    rst = 1'b1;
    sbq.delete();
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    chk_quiet();
    idle(3);

    // Frame D restarts cleanly at address 0
    do_start();
    for (int k = 12; k < 16; k++) send_idx(k);
    wait_done(32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
